// File: rtl/spike_event_encoder.sv
// Sequential spike-vector encoder: captures an N-bit spike vector and emits one neuron address per handshake.
// Optional `SPK_MERGE_EN lets new vectors be OR-merged into the pending set while events are still being emitted.
module spike_event_encoder #(
  parameter int N         = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         spk_i,
  input  logic                 spk_valid_i,
  output logic                 spk_ready_o,
  output logic [$clog2(N)-1:0] evt_addr_o,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic                 evt_last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int AW = $clog2(N);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           done_q, done_d;
  logic [AW-1:0]  prio_idx;
  logic [N-1:0]   emit_mask;
  logic           accept;
  logic           evt_hs;
  logic           in_emit;

  assign in_emit = (state_q == EMIT);

`ifdef SPK_MERGE_EN
  assign spk_ready_o = 1'b1;
`else
  assign spk_ready_o = !in_emit;
`endif

  assign accept = spk_valid_i && spk_ready_o;
  assign evt_hs = in_emit && evt_ready_i;

  // Later matches overwrite earlier ones, so scan order selects the priority.
  always_comb begin
    prio_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (pending_q[i]) prio_idx = AW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pending_q[i]) prio_idx = AW'(i);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_emit_mask
      assign emit_mask[gi] = evt_hs && (prio_idx == AW'(gi));
    end
  endgenerate

  // A merged bit equal to the one just emitted is re-queued because the OR comes last.
  always_comb begin
    pending_d = (pending_q & ~emit_mask) | (accept ? spk_i : '0);
    state_d   = (pending_d != '0) ? EMIT : IDLE;
    done_d    = (!in_emit && accept && (spk_i == '0)) ||
                (evt_hs && (pending_d == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign evt_valid_o = in_emit;
  assign busy_o      = in_emit;
  assign evt_addr_o  = in_emit ? prio_idx : '0;
  assign evt_last_o  = in_emit && (pending_q != '0) &&
                       ((pending_q & (pending_q - N'(1))) == '0);
  assign done_o      = done_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: table of frames on an MSB-first and an LSB-first
// instance, plus hand-written stall, empty-frame, mid-frame-reset and merge sequences.
module tb_spike_event_encoder;

  localparam int N = 16;
`ifdef SPK_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] spk       [2];
  logic         spk_valid [2];
  logic         spk_ready [2];
  logic [3:0]   addr      [2];
  logic         evt_valid [2];
  logic         evt_ready [2];
  logic         evt_last  [2];
  logic         busy      [2];
  logic         done      [2];

  always #5 clk = ~clk;

  spike_event_encoder #(.N(N), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .spk_i(spk[0]), .spk_valid_i(spk_valid[0]),
    .spk_ready_o(spk_ready[0]), .evt_addr_o(addr[0]), .evt_valid_o(evt_valid[0]),
    .evt_ready_i(evt_ready[0]), .evt_last_o(evt_last[0]), .busy_o(busy[0]),
    .done_o(done[0])
  );

  spike_event_encoder #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .spk_i(spk[1]), .spk_valid_i(spk_valid[1]),
    .spk_ready_o(spk_ready[1]), .evt_addr_o(addr[1]), .evt_valid_o(evt_valid[1]),
    .evt_ready_i(evt_ready[1]), .evt_last_o(evt_last[1]), .busy_o(busy[1]),
    .done_o(done[1])
  );

  typedef struct {
    logic [N-1:0] spk;
    int           dut;    // 0: MSB-first instance, 1: LSB-first instance
    int           k;      // expected number of events
    logic [63:0]  addrs;  // expected addresses, first event in the low nibble
  } vec_t;

  vec_t tbl [10];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    chk({tag, " evt_valid"}, 32'(evt_valid[d]), 32'd0);
    chk({tag, " evt_last"},  32'(evt_last[d]),  32'd0);
    chk({tag, " busy"},      32'(busy[d]),      32'd0);
    chk({tag, " evt_addr"},  32'(addr[d]),      32'd0);
    chk({tag, " spk_ready"}, 32'(spk_ready[d]), 32'd1);
  endtask

  task automatic run_frame(input vec_t v);
    int d;
    d = v.dut;
    @(posedge clk); #1;
    spk[d] = v.spk; spk_valid[d] = 1'b1; evt_ready[d] = 1'b1;
    @(negedge clk);
    chk("accept spk_ready", 32'(spk_ready[d]), 32'd1);
    @(posedge clk); #1;
    spk_valid[d] = 1'b0; spk[d] = '0;
    for (int i = 0; i < v.k; i++) begin
      @(negedge clk);
      chk("frame evt_valid", 32'(evt_valid[d]), 32'd1);
      chk("frame evt_addr",  32'(addr[d]), 32'(v.addrs[i*4 +: 4]));
      chk("frame evt_last",  32'(evt_last[d]), 32'(i == v.k - 1));
      chk("frame busy",      32'(busy[d]), 32'd1);
      chk("frame spk_ready", 32'(spk_ready[d]), 32'(MERGE));
      chk("frame no done",   32'(done[d]), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("frame done pulse", 32'(done[d]), 32'd1);
    chk("frame end valid",  32'(evt_valid[d]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("frame done clear", 32'(done[d]), 32'd0);
    $display("frame spk=%h dut=%0d events=%0d errors=%0d", v.spk, d, v.k, errors);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{spk: 16'h8421, dut: 0, k: 4,  addrs: 64'h05AF};
    tbl[1] = '{spk: 16'h8421, dut: 1, k: 4,  addrs: 64'hFA50};
    tbl[2] = '{spk: 16'h0001, dut: 0, k: 1,  addrs: 64'h0};
    tbl[3] = '{spk: 16'h8000, dut: 1, k: 1,  addrs: 64'hF};
    tbl[4] = '{spk: 16'h0300, dut: 0, k: 2,  addrs: 64'h89};
    tbl[5] = '{spk: 16'h0300, dut: 1, k: 2,  addrs: 64'h98};
    tbl[6] = '{spk: 16'h1024, dut: 0, k: 3,  addrs: 64'h25C};
    tbl[7] = '{spk: 16'h1024, dut: 1, k: 3,  addrs: 64'hC52};
    tbl[8] = '{spk: 16'hFFFF, dut: 0, k: 16, addrs: 64'h0123456789ABCDEF};
    tbl[9] = '{spk: 16'hFFFF, dut: 1, k: 16, addrs: 64'hFEDCBA9876543210};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      spk[d] = '0; spk_valid[d] = 1'b0; evt_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_idle(d, "reset");
      chk("reset done", 32'(done[d]), 32'd0);
    end
    $display("reset released errors=%0d", errors);

    for (int t = 0; t < 10; t++) run_frame(tbl[t]);

    // Stall: 0x0003 with evt_ready low for three cycles after the first valid.
    @(posedge clk); #1;
    spk[0] = 16'h0003; spk_valid[0] = 1'b1; evt_ready[0] = 1'b0;
    @(posedge clk); #1;
    spk_valid[0] = 1'b0; spk[0] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall evt_valid", 32'(evt_valid[0]), 32'd1);
      chk("stall evt_addr",  32'(addr[0]), 32'd1);
      chk("stall evt_last",  32'(evt_last[0]), 32'd0);
      @(posedge clk);
    end
    #1 evt_ready[0] = 1'b1;
    @(negedge clk);
    chk("stall resume addr", 32'(addr[0]), 32'd1);
    chk("stall resume valid", 32'(evt_valid[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("stall second addr", 32'(addr[0]), 32'd0);
    chk("stall second last", 32'(evt_last[0]), 32'd1);
    chk("stall second valid", 32'(evt_valid[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("stall done", 32'(done[0]), 32'd1);
    chk("stall end valid", 32'(evt_valid[0]), 32'd0);
    $display("stall sequence spk=0003 errors=%0d", errors);

    // Empty frame.
    @(posedge clk); #1;
    spk[0] = '0; spk_valid[0] = 1'b1;
    @(posedge clk); #1;
    spk_valid[0] = 1'b0;
    @(negedge clk);
    chk("empty done", 32'(done[0]), 32'd1);
    check_idle(0, "empty");
    @(posedge clk);
    @(negedge clk);
    chk("empty done clear", 32'(done[0]), 32'd0);
    chk("empty spk_ready", 32'(spk_ready[0]), 32'd1);
    $display("empty frame errors=%0d", errors);

    // Reset after five events of an all-ones frame.
    @(posedge clk); #1;
    spk[0] = 16'hFFFF; spk_valid[0] = 1'b1; evt_ready[0] = 1'b1;
    @(posedge clk); #1;
    spk_valid[0] = 1'b0; spk[0] = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("prereset addr", 32'(addr[0]), 32'(15 - i));
      @(posedge clk);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("midreset evt_valid", 32'(evt_valid[0]), 32'd0);
    chk("midreset evt_last",  32'(evt_last[0]), 32'd0);
    chk("midreset busy",      32'(busy[0]), 32'd0);
    chk("midreset evt_addr",  32'(addr[0]), 32'd0);
    chk("midreset done",      32'(done[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midreset held done", 32'(done[0]), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, "postreset");
    chk("postreset done", 32'(done[0]), 32'd0);
    $display("mid-frame reset errors=%0d", errors);
    run_frame('{spk: 16'h0010, dut: 0, k: 1, addrs: 64'h4});

`ifdef SPK_MERGE_EN
    // Merge of 0x0002 on the same cycle as the final handshake of frame 0x0100.
    @(posedge clk); #1;
    spk[0] = 16'h0100; spk_valid[0] = 1'b1; evt_ready[0] = 1'b1;
    @(posedge clk); #1;
    spk[0] = 16'h0002; spk_valid[0] = 1'b1;
    @(negedge clk);
    chk("merge first addr", 32'(addr[0]), 32'd8);
    chk("merge first last", 32'(evt_last[0]), 32'd1);
    chk("merge spk_ready",  32'(spk_ready[0]), 32'd1);
    @(posedge clk); #1;
    spk_valid[0] = 1'b0; spk[0] = '0;
    @(negedge clk);
    chk("merge no early done", 32'(done[0]), 32'd0);
    chk("merge second valid", 32'(evt_valid[0]), 32'd1);
    chk("merge second addr",  32'(addr[0]), 32'd1);
    chk("merge second last",  32'(evt_last[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("merge done", 32'(done[0]), 32'd1);
    chk("merge end valid", 32'(evt_valid[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("merge done clear", 32'(done[0]), 32'd0);
    $display("merge sequence errors=%0d", errors);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
